spi_slave_tx: RTL and testbench

SPI slave transmitter (VoSPI-style, read-only). Accepts bytes on an AXI-stream slave port and shifts them out MSB-first on MISO under control of an external SPI master's spi_clk/spi_cs. Sits opposite spi_master. Serves as the camera-side emulator for loopback benches and for FPGA self-test builds. MOSI is not used.

---
 rtl/spi_slave_tx.sv | 149 ++++++++++++++
 tb/tb_spi_slave_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_tx.sv
// SPI mode-3 slave transmitter: AXI-stream words shifted out MSB-first on MISO,
// with a one-deep holding register and FILL_WORD substitution on underrun.
module spi_slave_tx #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD   = 'h0F,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  spi_clk,
  input  logic                  spi_cs,
  output logic                  spi_miso,
  output logic                  busy,
  output logic                  underrun
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_reg, cs_sync_reg;
  logic                   sclk_d_reg, cs_d_reg;
  logic                   sclk_s, cs_s, fall_stb, cs_fall;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0]  shreg_reg, shreg_next;
  logic [DATA_WIDTH-1:0]  hold_data_reg, hold_data_next;
  logic                   hold_valid_reg, hold_valid_next;
  logic                   miso_reg, miso_next;
  logic                   underrun_reg, underrun_next;
  logic                   load;
  logic [DATA_WIDTH-1:0]  word;

  // Synchronisers preset to the idle bus levels so reset never looks like an edge.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            sclk_sync_reg[gi] <= 1'b1;
            cs_sync_reg[gi]   <= 1'b1;
          end else begin
            sclk_sync_reg[gi] <= spi_clk;
            cs_sync_reg[gi]   <= spi_cs;
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            sclk_sync_reg[gi] <= 1'b1;
            cs_sync_reg[gi]   <= 1'b1;
          end else begin
            sclk_sync_reg[gi] <= sclk_sync_reg[gi-1];
            cs_sync_reg[gi]   <= cs_sync_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign sclk_s   = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_s     = cs_sync_reg[SYNC_STAGES-1];
  assign fall_stb = sclk_d_reg & ~sclk_s;
  assign cs_fall  = cs_d_reg & ~cs_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_d_reg     <= 1'b1;
      cs_d_reg       <= 1'b1;
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shreg_reg      <= '0;
      hold_data_reg  <= '0;
      hold_valid_reg <= 1'b0;
      miso_reg       <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      sclk_d_reg     <= sclk_s;
      cs_d_reg       <= cs_s;
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shreg_reg      <= shreg_next;
      hold_data_reg  <= hold_data_next;
      hold_valid_reg <= hold_valid_next;
      miso_reg       <= miso_next;
      underrun_reg   <= underrun_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shreg_next      = shreg_reg;
    hold_data_next  = hold_data_reg;
    hold_valid_next = hold_valid_reg;
    miso_next       = miso_reg;
    underrun_next   = 1'b0;
    load            = 1'b0;
    word            = hold_valid_reg ? hold_data_reg : FILL_WORD;

    case (state_reg)
      IDLE: begin
        miso_next    = 1'b0;
        bit_cnt_next = '0;
        if (cs_fall) state_next = SHIFT;
      end
      SHIFT: begin
        // CS release takes priority over a coincident falling edge; partial word is dropped.
        if (cs_s) begin
          state_next   = IDLE;
          miso_next    = 1'b0;
          bit_cnt_next = '0;
        end else if (fall_stb) begin
          if (bit_cnt_reg == '0) begin
            load          = 1'b1;
            underrun_next = ~hold_valid_reg;
            miso_next     = word[DATA_WIDTH-1];
            shreg_next    = {word[DATA_WIDTH-2:0], 1'b0};
          end else begin
            miso_next  = shreg_reg[DATA_WIDTH-1];
            shreg_next = {shreg_reg[DATA_WIDTH-2:0], 1'b0};
          end
          bit_cnt_next = (bit_cnt_reg == LAST_BIT) ? '0 : bit_cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // Accept only when empty, so a consume and an accept can never collide.
    if (load && hold_valid_reg) begin
      hold_valid_next = 1'b0;
    end else if (s_axis_tvalid && !hold_valid_reg) begin
      hold_valid_next = 1'b1;
      hold_data_next  = s_axis_tdata;
    end
  end

  assign s_axis_tready = ~hold_valid_reg;
  assign spi_miso      = miso_reg;
  assign busy          = (state_reg == SHIFT);
  assign underrun      = underrun_reg;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Bench for spi_slave_tx: bit-banged mode-3 master, AXI feeder queue, table vectors,
// randomized frames against a word-queue model, and hand-written corner sequences.
module tb_spi_slave_tx;
  localparam logic [7:0] FILL = 8'h0F;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       spi_clk;
  logic       spi_cs;
  logic       spi_miso;
  logic       busy;
  logic       underrun;

  spi_slave_tx #(.DATA_WIDTH(8), .FILL_WORD(8'h0F), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_miso(spi_miso),
    .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] axi_q[$];
  logic       rx_q[$];
  int         und_cnt = 0;
  int         und_wide = 0;
  logic       und_prev = 1'b0;

  typedef struct {
    logic [7:0] d[4];
    int         nd;
    int         nw;
    logic [7:0] exp[4];
    int         und;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // AXI feeder: presents the queue head; pops once the handshake is certain for the next edge.
  initial begin
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    forever begin
      @(negedge clk);
      if (axi_q.size() > 0 && !rst) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = axi_q[0];
      end else begin
        s_axis_tvalid = 1'b0;
      end
      #1;
      if (s_axis_tvalid && s_axis_tready && !rst) void'(axi_q.pop_front());
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (underrun) begin
        und_cnt++;
        if (und_prev) und_wide++;
      end
      und_prev = underrun;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // One master bit: fall, wait half period, sample MISO, rise, wait half period.
  task automatic spi_bit();
    @(posedge clk);
    #1 spi_clk = 1'b0;
    tick(8);
    rx_q.push_back(spi_miso);
    spi_clk = 1'b1;
    tick(8);
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    tick(6);
  endtask

  task automatic cs_high();
    tick(2);
    spi_cs = 1'b1;
    tick(6);
  endtask

  task automatic pop_bits(input int n, output logic [7:0] b);
    b = '0;
    for (int i = 0; i < n; i++) begin
      if (rx_q.size() > 0) b = {b[6:0], rx_q.pop_front()};
      else b = {b[6:0], 1'bx};
    end
  endtask

  task automatic wait_hold_full(input string name);
    for (int t = 0; t < 50; t++) begin
      if (!s_axis_tready) break;
      tick(1);
    end
    chk(name, s_axis_tready, 0);
  endtask

  task automatic run_frame(input string tag, input vec_t v);
    int u0;
    logic [7:0] b;
    u0 = und_cnt;
    rx_q.delete();
    for (int i = 0; i < v.nd; i++) axi_q.push_back(v.d[i]);
    if (v.nd > 0) wait_hold_full({tag, "_hold"});
    cs_low();
    chk({tag, "_busy"}, busy, 1);
    for (int i = 0; i < v.nw * 8; i++) spi_bit();
    cs_high();
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_miso"}, spi_miso, 0);
    for (int w = 0; w < v.nw; w++) begin
      pop_bits(8, b);
      chk($sformatf("%s_word%0d", tag, w), b, v.exp[w]);
      $display("%s word %0d: read %02h expect %02h", tag, w, b, v.exp[w]);
    end
    chk({tag, "_underruns"}, und_cnt - u0, v.und);
  endtask

  vec_t tbl[3];
  vec_t rv;
  logic [7:0] model_q[$];
  logic [7:0] b;
  int u0;

  initial begin
    rst = 1'b1; spi_clk = 1'b1; spi_cs = 1'b1;
    tick(3);
    chk("rst_miso", spi_miso, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_tready", s_axis_tready, 1);
    rst = 1'b0;
    tick(4);
    chk("post_rst_busy", busy, 0);

    // Latency / tready timing on 0xA5: MISO goes 0->1 exactly 3 clks after the fall.
    u0 = und_cnt;
    rx_q.delete();
    axi_q.push_back(8'hA5);
    wait_hold_full("lat_hold");
    cs_low();
    @(posedge clk);
    #1 spi_clk = 1'b0;
    tick(2);
    chk("lat_miso_2clk", spi_miso, 0);
    chk("lat_tready_2clk", s_axis_tready, 0);
    tick(1);
    chk("lat_miso_3clk", spi_miso, 1);
    chk("lat_tready_3clk", s_axis_tready, 1);
    tick(5);
    rx_q.push_back(spi_miso);
    spi_clk = 1'b1;
    tick(8);
    for (int i = 0; i < 7; i++) spi_bit();
    cs_high();
    pop_bits(8, b);
    chk("lat_word", b, 8'hA5);
    chk("lat_underruns", und_cnt - u0, 0);
    $display("latency frame: read %02h", b);

    // Underrun pulse lands with the boundary load, one clk wide.
    u0 = und_cnt;
    rx_q.delete();
    cs_low();
    @(posedge clk);
    #1 spi_clk = 1'b0;
    tick(2);
    chk("und_before", underrun, 0);
    tick(1);
    chk("und_pulse", underrun, 1);
    tick(1);
    chk("und_after", underrun, 0);
    tick(4);
    rx_q.push_back(spi_miso);
    spi_clk = 1'b1;
    tick(8);
    for (int i = 0; i < 7; i++) spi_bit();
    cs_high();
    pop_bits(8, b);
    chk("und_word", b, FILL);
    chk("und_count", und_cnt - u0, 1);
    $display("underrun frame: read %02h", b);

    tbl[0].d = '{8'hA5, 8'h00, 8'h00, 8'h00}; tbl[0].nd = 1; tbl[0].nw = 1;
    tbl[0].exp = '{8'hA5, 8'h00, 8'h00, 8'h00}; tbl[0].und = 0;
    tbl[1].d = '{8'h12, 8'h34, 8'h56, 8'h00}; tbl[1].nd = 3; tbl[1].nw = 3;
    tbl[1].exp = '{8'h12, 8'h34, 8'h56, 8'h00}; tbl[1].und = 0;
    tbl[2].d = '{8'h00, 8'h00, 8'h00, 8'h00}; tbl[2].nd = 0; tbl[2].nw = 2;
    tbl[2].exp = '{8'h0F, 8'h0F, 8'h00, 8'h00}; tbl[2].und = 2;
    for (int i = 0; i < 3; i++) run_frame($sformatf("tbl%0d", i), tbl[i]);

    // Randomized frames: expected words come from a queue drained at each word boundary.
    for (int r = 0; r < 6; r++) begin
      rv.nd = int'($urandom_range(0, 3));
      rv.nw = rv.nd + int'($urandom_range(0, 1));
      if (rv.nw == 0) rv.nw = 1;
      model_q.delete();
      for (int i = 0; i < 4; i++) begin
        rv.d[i] = 8'($urandom);
        if (i < rv.nd) model_q.push_back(rv.d[i]);
      end
      rv.und = 0;
      for (int w = 0; w < 4; w++) begin
        rv.exp[w] = 8'h00;
        if (w < rv.nw) begin
          if (model_q.size() > 0) rv.exp[w] = model_q.pop_front();
          else begin
            rv.exp[w] = FILL;
            rv.und++;
          end
        end
      end
      run_frame($sformatf("rnd%0d", r), rv);
    end

    // CS released after 4 bits of 0xC3: remainder dropped, next frame sends 0x99.
    u0 = und_cnt;
    rx_q.delete();
    axi_q.push_back(8'hC3);
    axi_q.push_back(8'h99);
    wait_hold_full("part_hold");
    cs_low();
    for (int i = 0; i < 4; i++) spi_bit();
    cs_high();
    chk("part_idle_miso", spi_miso, 0);
    chk("part_hold_kept", s_axis_tready, 0);
    pop_bits(4, b);
    chk("part_nibble", b, 8'h0C);
    cs_low();
    for (int i = 0; i < 8; i++) spi_bit();
    cs_high();
    pop_bits(8, b);
    chk("part_next_word", b, 8'h99);
    chk("part_underruns", und_cnt - u0, 0);
    $display("partial frame: next word %02h", b);

    // Reset in the middle of 0xFF, then a fill word after release.
    rx_q.delete();
    axi_q.push_back(8'hFF);
    wait_hold_full("rstmid_hold");
    cs_low();
    for (int i = 0; i < 4; i++) spi_bit();
    chk("rstmid_miso_before", spi_miso, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_miso", spi_miso, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_tready", s_axis_tready, 1);
    tick(2);
    rst = 1'b0;
    tick(6);
    chk("rstmid_rebusy", busy, 1);
    u0 = und_cnt;
    rx_q.delete();
    for (int i = 0; i < 8; i++) spi_bit();
    cs_high();
    pop_bits(8, b);
    chk("rstmid_fill", b, FILL);
    chk("rstmid_underruns", und_cnt - u0, 1);
    $display("reset frame: read %02h", b);

    chk("underrun_width", und_wide, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
